// File: rtl/sta_arc_eval.sv
// ----------------------------------------------------------------------------
//  sta_arc_eval : streaming per-cell arc evaluation (max of arrival + delay)
//  Revision     : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module sta_arc_eval #(
   parameter int AW   = 24,
   parameter int DW   = 16,
   parameter int IDXW = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            arc_valid_i,
   output logic            arc_ready_o,
   input  logic [AW-1:0]   arc_arrival_i,
   input  logic [DW-1:0]   arc_delay_i,
   input  logic            arc_last_i,
   output logic            res_valid_o,
   input  logic            res_ready_i,
   output logic [AW-1:0]   res_arrival_o,
   output logic [IDXW-1:0] res_crit_idx_o,
   output logic [IDXW:0]   res_arc_cnt_o,
   output logic            res_sat_o,
   output logic            res_ovf_o
);

   localparam logic [IDXW:0] CNT_MAX = {1'b1, {IDXW{1'b0}}};

   typedef enum logic [0:0] {S_EMPTY = 1'b0, S_ACCUM = 1'b1} state_t;

   state_t          state_q;
   logic [AW-1:0]   acc_q,  acc_d;
   logic [IDXW-1:0] idx_q,  idx_d;
   logic [IDXW:0]   cnt_q,  cnt_d;
   logic            sat_q,  sat_d;
   logic            ovf_q,  ovf_d;

   logic            res_valid_q, res_valid_d;
   logic [AW-1:0]   res_arrival_q;
   logic [IDXW-1:0] res_idx_q;
   logic [IDXW:0]   res_cnt_q;
   logic            res_sat_q;
   logic            res_ovf_q;

   logic [AW:0]     w_sum;
   logic            w_sum_sat;
   logic [AW-1:0]   w_sum_clamped;
   logic            w_accept;
   logic            w_full;
   logic            w_win;

   assign arc_ready_o   = !res_valid_q || res_ready_i;
   assign w_accept      = arc_valid_i && arc_ready_o;

   assign w_sum         = {1'b0, arc_arrival_i} + (AW+1)'(arc_delay_i);
   assign w_sum_sat     = w_sum[AW];
   assign w_sum_clamped = w_sum_sat ? {AW{1'b1}} : w_sum[AW-1:0];

   // Once 2^IDXW arcs are counted, a winning extra arc pins idx at the top slot.
   assign w_full = (cnt_q == CNT_MAX);
   assign w_win  = (w_sum_clamped > acc_q);

   always_comb begin
      acc_d = w_sum_clamped;
      idx_d = '0;
      cnt_d = (IDXW+1)'(1);
      sat_d = w_sum_sat;
      ovf_d = 1'b0;
      if (state_q == S_ACCUM) begin
         acc_d = w_win ? w_sum_clamped : acc_q;
         idx_d = w_win ? (w_full ? {IDXW{1'b1}} : cnt_q[IDXW-1:0]) : idx_q;
         cnt_d = w_full ? cnt_q : cnt_q + 1'b1;
         sat_d = sat_q | w_sum_sat;
         ovf_d = ovf_q | w_full;
      end
   end

   always_comb begin
      res_valid_d = res_valid_q;
      if (w_accept && arc_last_i) res_valid_d = 1'b1;
      else if (res_ready_i)       res_valid_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_EMPTY;
         acc_q         <= '0;
         idx_q         <= '0;
         cnt_q         <= '0;
         sat_q         <= 1'b0;
         ovf_q         <= 1'b0;
         res_valid_q   <= 1'b0;
         res_arrival_q <= '0;
         res_idx_q     <= '0;
         res_cnt_q     <= '0;
         res_sat_q     <= 1'b0;
         res_ovf_q     <= 1'b0;
      end else begin
         res_valid_q <= res_valid_d;
         if (w_accept) begin
            state_q <= arc_last_i ? S_EMPTY : S_ACCUM;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
            if (arc_last_i) begin
               res_arrival_q <= acc_d;
               res_idx_q     <= idx_d;
               res_cnt_q     <= cnt_d;
               res_sat_q     <= sat_d;
               res_ovf_q     <= ovf_d;
            end
         end
      end
   end

   assign res_valid_o    = res_valid_q;
   assign res_arrival_o  = res_arrival_q;
   assign res_crit_idx_o = res_idx_q;
   assign res_arc_cnt_o  = res_cnt_q;
   assign res_sat_o      = res_sat_q;
   assign res_ovf_o      = res_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_sta_arc_eval.sv
// ----------------------------------------------------------------------------
//  tb_sta_arc_eval : directed self-checking bench for sta_arc_eval
//  Revision        : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sta_arc_eval;

   localparam int AW   = 24;
   localparam int DW   = 16;
   localparam int IDXW = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            arc_valid_i;
   logic            arc_ready_o;
   logic [AW-1:0]   arc_arrival_i;
   logic [DW-1:0]   arc_delay_i;
   logic            arc_last_i;
   logic            res_valid_o;
   logic            res_ready_i;
   logic [AW-1:0]   res_arrival_o;
   logic [IDXW-1:0] res_crit_idx_o;
   logic [IDXW:0]   res_arc_cnt_o;
   logic            res_sat_o;
   logic            res_ovf_o;

   int n_cmp = 0;
   int n_err = 0;

   sta_arc_eval #(.AW(AW), .DW(DW), .IDXW(IDXW)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .arc_valid_i   (arc_valid_i),
      .arc_ready_o   (arc_ready_o),
      .arc_arrival_i (arc_arrival_i),
      .arc_delay_i   (arc_delay_i),
      .arc_last_i    (arc_last_i),
      .res_valid_o   (res_valid_o),
      .res_ready_i   (res_ready_i),
      .res_arrival_o (res_arrival_o),
      .res_crit_idx_o(res_crit_idx_o),
      .res_arc_cnt_o (res_arc_cnt_o),
      .res_sat_o     (res_sat_o),
      .res_ovf_o     (res_ovf_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one arc and returns 1 ns after the edge that accepted it.
   task automatic send_arc(input int arr, input int dly, input bit last);
      int budget;
      arc_valid_i   = 1'b1;
      arc_arrival_i = AW'(arr);
      arc_delay_i   = DW'(dly);
      arc_last_i    = last;
      budget        = 20;
      while (!arc_ready_o && budget > 0) begin
         tick();
         budget--;
      end
      if (budget == 0) check("accept_timeout", 0, 1);
      tick();
      arc_valid_i = 1'b0;
      arc_last_i  = 1'b0;
   endtask

   // Checks the held result, then completes the handshake.
   task automatic take_res(input string tag, input int arr, input int idx,
                           input int cnt, input int sat, input int ovf);
      check({tag, "_valid"}, 32'(res_valid_o),    1);
      check({tag, "_arr"},   32'(res_arrival_o),  32'(arr));
      check({tag, "_idx"},   32'(res_crit_idx_o), 32'(idx));
      check({tag, "_cnt"},   32'(res_arc_cnt_o),  32'(cnt));
      check({tag, "_sat"},   32'(res_sat_o),      32'(sat));
      check({tag, "_ovf"},   32'(res_ovf_o),      32'(ovf));
      res_ready_i = 1'b1;
      tick();
      res_ready_i = 1'b0;
      check({tag, "_drained"}, 32'(res_valid_o), 0);
   endtask

   initial begin
      rst_n         = 1'b0;
      arc_valid_i   = 1'b0;
      arc_arrival_i = '0;
      arc_delay_i   = '0;
      arc_last_i    = 1'b0;
      res_ready_i   = 1'b0;
      #1;
      check("rst_ready", 32'(arc_ready_o), 1);
      check("rst_valid", 32'(res_valid_o), 0);
      check("rst_arr",   32'(res_arrival_o), 0);
      check("rst_cnt",   32'(res_arc_cnt_o), 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Reset in the middle of a cell drops the partial accumulation.
      send_arc(9000, 9000, 1'b0);
      send_arc(100, 50000, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_ready", 32'(arc_ready_o), 1);
      check("midrst_valid", 32'(res_valid_o), 0);
      tick();
      rst_n = 1'b1;
      tick();
      send_arc(500, 1502, 1'b1);
      take_res("single", 2002, 0, 1, 0, 0);

      // AOI21: 7069, 7255, 7426 -> last arc wins
      send_arc(1000, 6069, 1'b0);
      send_arc(1000, 6255, 1'b0);
      check("aoi_pre_valid", 32'(res_valid_o), 0);
      send_arc(3000, 4426, 1'b1);
      take_res("aoi21", 7426, 2, 3, 0, 0);

      // Tie keeps the earlier arc
      send_arc(0, 3000, 1'b0);
      send_arc(1000, 2000, 1'b1);
      take_res("tie", 3000, 0, 2, 0, 0);

      // 16777000 + 8970 exceeds 2^24-1 and clamps
      send_arc(16777000, 8970, 1'b0);
      send_arc(100, 100, 1'b1);
      take_res("sat", 16777215, 0, 2, 1, 0);

      // Nine arcs into an eight-slot cell
      for (int i = 1; i <= 9; i++) send_arc(0, i, i == 9);
      take_res("ovf", 9, 7, 8, 0, 1);

      // Backpressure: cell A (110, 220) then cell B (55, 140)
      send_arc(100, 10, 1'b0);
      send_arc(200, 20, 1'b1);
      arc_valid_i   = 1'b1;
      arc_arrival_i = AW'(50);
      arc_delay_i   = DW'(5);
      arc_last_i    = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_ready", 32'(arc_ready_o),   0);
         check("bp_valid", 32'(res_valid_o),   1);
         check("bp_arr",   32'(res_arrival_o), 220);
         tick();
      end
      check("bp_a_idx", 32'(res_crit_idx_o), 1);
      check("bp_a_cnt", 32'(res_arc_cnt_o),  2);
      res_ready_i = 1'b1;
      tick();
      res_ready_i = 1'b0;
      arc_valid_i = 1'b0;
      check("bp_a_drained", 32'(res_valid_o), 0);
      send_arc(40, 100, 1'b1);
      take_res("bp_b", 140, 1, 2, 0, 0);

      // Back-to-back cells with downstream always ready
      res_ready_i = 1'b1;
      send_arc(7, 3, 1'b1);
      check("b2b_c_valid", 32'(res_valid_o),   1);
      check("b2b_c_arr",   32'(res_arrival_o), 10);
      send_arc(1, 1, 1'b0);
      check("b2b_c_gone",  32'(res_valid_o),   0);
      send_arc(2, 2, 1'b1);
      check("b2b_d_valid", 32'(res_valid_o),   1);
      check("b2b_d_arr",   32'(res_arrival_o), 4);
      check("b2b_d_idx",   32'(res_crit_idx_o), 1);
      res_ready_i = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sta_arc_eval.md
# sta_arc_eval

Streaming arc-evaluation stage of the hardware timing engine. It consumes per-arc records from the library lookup stage, where each record is an input-pin arrival time plus that pin's pin-to-output delay from the cell library. For each cell instance it produces the output-pin arrival as max(arrival + delay), the index of the critical input arc, and status flags. Its output feeds the net-propagation stage, which uses the result as the arrival time at the driven pins.

## Interface
- `AW`, default 24: arrival-time width, unsigned fixed point, 1 LSB = 0.00001 ns.
- `DW`, default 16: arc-delay width, same LSB (library value 0.08970 is encoded as 8970).
- `IDXW`, default 3: arc-index width; up to 2^IDXW arcs per cell.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `arc_valid`  in  1: an arc record is presented.
- `arc_ready`  out  1: the stage accepts the record this cycle.
- `arc_arrival`  in  AW: arrival time at the arc's input pin.
- `arc_delay`  in  DW: pin-to-output delay of the arc.
- `arc_last`  in  1: this is the final arc of the current cell instance.
- `res_valid`  out  1: a result is held.
- `res_ready`  in  1: downstream takes the result.
- `res_arrival`  out  AW: worst output arrival.
- `res_crit_idx`  out  IDXW: position of the critical arc within the cell, where 0 is the first arc.
- `res_arc_cnt`  out  IDXW+1: number of arcs accepted for the cell, saturating at 2^IDXW.
- `res_sat`  out  1: at least one arc sum saturated.
- `res_ovf`  out  1: the cell presented more than 2^IDXW arcs.

## Operation
- An arc is accepted when `arc_valid && arc_ready`.
- `arc_ready = !res_valid || res_ready`. The ready signal is combinational from output state only and never depends on `arc_*`.
- Sum: s = `arc_arrival` + zero-extended `arc_delay`, computed at AW+1 bits. If bit AW is set, s clamps to 2^AW−1 and the cell's sat flag is set.
- Accumulator states:
  - **EMPTY** (no arc of the current cell yet): an accepted arc loads acc=s, idx=0, cnt=1. The cell's sat flag loads from this arc and ovf loads 0.
  - **ACCUM** (one or more arcs taken): an accepted arc with s > acc, strictly greater, loads acc=s and idx=cnt. On a tie the earlier, lower index is kept.
  - On each accepted arc in ACCUM:
    - cnt increments, saturating at 2^IDXW.
    - Once cnt == 2^IDXW, any further arc sets ovf. That arc still takes part in the max, but idx stays at 2^IDXW−1 if that arc wins.
    - The sat flag ORs in the arc's sat.
- Accepted arc with `arc_last`=1:
  - The final acc/idx/cnt/sat/ovf, including this arc, are written to the result registers, `res_valid`←1, and the accumulator returns to EMPTY.
  - A single-arc cell (EMPTY with `arc_last`) is legal and produces cnt=1, idx=0.
- Result registers hold steady while `res_valid && !res_ready`.
  - `res_valid` clears on `res_ready` unless a new last arc is accepted in the same cycle.
  - If a new last arc is accepted in that same cycle, the result registers reload and `res_valid` stays 1.
- When `arc_valid` is low, state does not change.

## Timing
- Reset, asynchronous and immediate on `rst_n` low:
  - `res_valid`=0, `res_arrival`=0, `res_crit_idx`=0, `res_arc_cnt`=0, `res_sat`=0, `res_ovf`=0.
  - Accumulator goes to EMPTY and any partial cell is discarded.
  - `arc_ready` is 1 during and after reset.
- Latency: `res_valid` rises on the clock edge that accepts the last arc, i.e. it is visible the cycle after acceptance.
- Throughput: 1 arc/cycle sustained while downstream keeps `res_ready` high. Back-to-back cells need no gap cycle.
- Backpressure: while `res_valid && !res_ready`, `arc_ready`=0 and no arc is accepted, including non-last arcs.
- Output data is stable from the `res_valid` rise until the handshake completes.

## Test plan
- **Reset:** assert `rst_n`=0 mid-cell after 2 arcs, release, then send 1 arc (arrival 500, delay 1502, last) → res_arrival=2002, idx=0, cnt=1; no trace of the earlier partial cell.
- **AOI21 cell:**
  - Stimulus: arcs (1000,6069), (1000,6255), (3000,4426, last).
  - Required response: res_arrival=7426, idx=2, cnt=3, sat=0, ovf=0; valid one cycle after the last accept.
- **Tie:** arcs (0,3000), (1000,2000, last) → res_arrival=3000, idx=0.
- **Saturation with AW=24:**
  - Stimulus: arcs (16777000,8970), (100,100, last).
  - Required response: res_arrival=16777215, idx=0, sat=1.
- **Overflow with IDXW=3:**
  - Stimulus: 9 arcs, arrival 0, delays 1..9; the ninth arc is last.
  - Required response: res_arrival=9, idx=7, cnt=8, ovf=1.
- **Backpressure:**
  - Stimulus: two 2-arc cells back-to-back; hold `res_ready`=0 for 5 cycles after the first result.
  - Required response: `arc_ready`=0 for those cycles, the first result is unchanged throughout, and the second result appears correctly after release with no lost or duplicated result.
